key_decode_hold: RTL and testbench

- Sits directly downstream of the matrix keypad scanner.
- Consumes the scanner's row drive, the synchronized column inputs and the one-cycle newNum pulse.
- Decodes the pressed key to a 4-bit hex code, rejects multi-key or ambiguous presses, and suppresses repeats of a held key within a holdoff window.
- Keeps a two-digit history (most recent and previous) for the dual seven-segment display driver.

---
 rtl/key_decode_hold.sv | 141 ++++++++++++++
 tb/tb_key_decode_hold.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_decode_hold.sv
// rtl/key_decode_hold.sv - keypad row/col decode with two-digit history and same-key repeat holdoff
module key_decode_hold #(
    parameter int HOLDOFF = 1000,
    parameter int CNT_W   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic [3:0] cols,
    input  logic       newNum,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] numValid,
    output logic       newDigit,
    output logic       keyErr
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLDOFF);

    typedef enum logic {
        IDLE,
        ARMED
    } hold_state_t;

    hold_state_t      state, state_next;
    logic [CNT_W-1:0] count;
    logic [3:0]       row_q, col_q;
    logic             row_ok, col_ok, sample_valid;
    logic [1:0]       row_idx, col_idx;
    logic [3:0]       code;
    logic             suppress, accept, invalid;

    function automatic logic one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] bit_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // The scanner pulses newNum one cycle after the hit, so decode works off the delayed sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= 4'd0;
            col_q <= 4'd0;
        end else begin
            row_q <= rows;
            col_q <= cols;
        end
    end

    always_comb begin
        row_ok       = one_hot(row_q);
        col_ok       = one_hot(col_q);
        sample_valid = row_ok && col_ok;
        row_idx      = bit_index(row_q);
        col_idx      = bit_index(col_q);
        code         = 4'h0;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
    end

    always_comb begin
        suppress = sample_valid && (state == ARMED) && (count < HOLD_MAX)
                   && (code == digit0) && (numValid != 2'd0);
        accept   = newNum && sample_valid && !suppress;
        invalid  = newNum && !sample_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = ARMED;
        end else if ((state == ARMED) && (count == HOLD_MAX)) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
        end else if ((state == ARMED) && (count < HOLD_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit0   <= 4'd0;
            digit1   <= 4'd0;
            numValid <= 2'd0;
            newDigit <= 1'b0;
            keyErr   <= 1'b0;
        end else begin
            newDigit <= accept;
            keyErr   <= invalid;
            if (accept) begin
                digit1 <= digit0;
                digit0 <= code;
                if (numValid != 2'd2) begin
                    numValid <= numValid + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_decode_hold.sv
// tb/tb_key_decode_hold.sv - randomized self-checking bench for key_decode_hold against a cycle-count model
module tb_key_decode_hold;

    localparam int HOLDOFF = 8;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       newNum;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [1:0] numValid;
    logic       newDigit;
    logic       keyErr;

    int n_cmp;
    int n_bad;

    // Reference state: what the outputs should read after the latest edge.
    logic [3:0] m_d0, m_d1;
    int         m_nv;
    logic       m_nd, m_ke;
    logic [3:0] m_pr, m_pc;
    int         cyc;
    int         m_last;

    logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};

    key_decode_hold #(.HOLDOFF(HOLDOFF), .CNT_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .newNum   (newNum),
        .digit0   (digit0),
        .digit1   (digit1),
        .numValid (numValid),
        .newDigit (newDigit),
        .keyErr   (keyErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_d0 = 4'd0; m_d1 = 4'd0; m_nv = 0; m_nd = 1'b0; m_ke = 1'b0;
        m_pr = 4'd0; m_pc = 4'd0; m_last = -1;
    endtask

    // Drive one cycle (called at a negedge), advance the model at the posedge, return at the next negedge.
    task automatic step(input logic [3:0] r, input logic [3:0] c, input logic nn);
        logic [3:0] k;
        rows = r; cols = c; newNum = nn;
        @(posedge clk);
        m_nd = 1'b0;
        m_ke = 1'b0;
        if (nn) begin
            if ($countones(m_pr) != 1 || $countones(m_pc) != 1) begin
                m_ke = 1'b1;
            end else begin
                k = key_map[$clog2(m_pr) * 4 + $clog2(m_pc)];
                if (!(m_last >= 0 && (cyc - m_last) <= HOLDOFF && k == m_d0 && m_nv != 0)) begin
                    m_d1 = m_d0;
                    m_d0 = k;
                    m_nv = (m_nv < 2) ? m_nv + 1 : 2;
                    m_nd = 1'b1;
                    m_last = cyc;
                end
            end
        end
        m_pr = r;
        m_pc = c;
        cyc++;
        @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        step(4'(1 << r), 4'(1 << c), 1'b0);
        step(4'd0, 4'd0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; rows = 4'd0; cols = 4'd0; newNum = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({digit0, digit1, numValid, newDigit, keyErr} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got d0=%h d1=%h nv=%0d nd=%b ke=%b want all zero",
                     digit0, digit1, numValid, newDigit, keyErr);
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_first_key();
        press(1, 2);
        n_cmp++;
        if (digit0 !== 4'h6 || digit1 !== 4'h0 || numValid !== 2'd1 || newDigit !== 1'b1) begin
            n_bad++;
            $display("FAIL first_key got d0=%h d1=%h nv=%0d nd=%b want d0=6 d1=0 nv=1 nd=1",
                     digit0, digit1, numValid, newDigit);
        end
        idle(1);
        n_cmp++;
        if (newDigit !== 1'b0) begin
            n_bad++;
            $display("FAIL first_key_pulse_width got nd=%b want 0", newDigit);
        end
    endtask

    task automatic test_history();
        press(0, 2);
        press(3, 1);
        n_cmp++;
        if (digit0 !== 4'h0 || digit1 !== 4'h3 || numValid !== 2'd2) begin
            n_bad++;
            $display("FAIL history_two got d0=%h d1=%h nv=%0d want d0=0 d1=3 nv=2", digit0, digit1, numValid);
        end
        press(0, 3);
        n_cmp++;
        if (digit0 !== 4'hA || digit1 !== 4'h0 || numValid !== 2'd2 || newDigit !== 1'b1) begin
            n_bad++;
            $display("FAIL history_saturate got d0=%h d1=%h nv=%0d nd=%b want d0=a d1=0 nv=2 nd=1",
                     digit0, digit1, numValid, newDigit);
        end
    endtask

    task automatic test_holdoff();
        idle(HOLDOFF + 2);
        press(1, 1);                  // accept 5 at cycle T
        idle(1);
        press(1, 1);                  // newNum at T+3: inside window
        n_cmp++;
        if (newDigit !== 1'b0 || digit0 !== 4'h5 || digit1 !== 4'hA) begin
            n_bad++;
            $display("FAIL holdoff_suppress got nd=%b d0=%h d1=%h want nd=0 d0=5 d1=a", newDigit, digit0, digit1);
        end
        idle(5);
        press(1, 1);                  // newNum at T+10: window expired
        n_cmp++;
        if (newDigit !== 1'b1 || digit0 !== 4'h5 || digit1 !== 4'h5) begin
            n_bad++;
            $display("FAIL holdoff_expired got nd=%b d0=%h d1=%h want nd=1 d0=5 d1=5", newDigit, digit0, digit1);
        end
    endtask

    task automatic test_diff_key();
        press(2, 2);
        n_cmp++;
        if (newDigit !== 1'b1 || digit0 !== 4'h9 || digit1 !== 4'h5) begin
            n_bad++;
            $display("FAIL diff_key got nd=%b d0=%h d1=%h want nd=1 d0=9 d1=5", newDigit, digit0, digit1);
        end
    endtask

    task automatic test_invalid();
        step(4'b0010, 4'b0110, 1'b0);
        step(4'd0, 4'd0, 1'b1);
        n_cmp++;
        if (keyErr !== 1'b1 || newDigit !== 1'b0 || digit0 !== 4'h9 || digit1 !== 4'h5 || numValid !== 2'd2) begin
            n_bad++;
            $display("FAIL invalid_two_cols got ke=%b nd=%b d0=%h d1=%h nv=%0d want ke=1 nd=0 d0=9 d1=5 nv=2",
                     keyErr, newDigit, digit0, digit1, numValid);
        end
        step(4'b0010, 4'b0000, 1'b0);
        step(4'd0, 4'd0, 1'b1);
        n_cmp++;
        if (keyErr !== 1'b1 || digit0 !== 4'h9 || numValid !== 2'd2) begin
            n_bad++;
            $display("FAIL invalid_no_col got ke=%b d0=%h nv=%0d want ke=1 d0=9 nv=2", keyErr, digit0, numValid);
        end
        idle(1);
        n_cmp++;
        if (keyErr !== 1'b0) begin
            n_bad++;
            $display("FAIL invalid_pulse_width got ke=%b want 0", keyErr);
        end
    endtask

    task automatic test_async_reset();
        press(3, 0);
        press(3, 2);                  // F accepted, holdoff armed, numValid=2
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({digit0, digit1, numValid, newDigit, keyErr} !== 12'd0) begin
            n_bad++;
            $display("FAIL async_reset got d0=%h d1=%h nv=%0d nd=%b ke=%b want all zero",
                     digit0, digit1, numValid, newDigit, keyErr);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        press(3, 2);
        n_cmp++;
        if (newDigit !== 1'b1 || digit0 !== 4'hF || numValid !== 2'd1) begin
            n_bad++;
            $display("FAIL post_reset_same_key got nd=%b d0=%h nv=%0d want nd=1 d0=f nv=1",
                     newDigit, digit0, numValid);
        end
    endtask

    task automatic test_random();
        logic [3:0] r, c;
        logic       nn;
        int         sel;
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) begin
                // small key pool so repeats land inside and outside the window
                r = 4'(1 << $urandom_range(0, 1));
                c = 4'(1 << $urandom_range(0, 1));
            end else begin
                r = 4'($urandom_range(0, 15));
                c = 4'($urandom_range(0, 15));
            end
            nn = ($urandom_range(0, 3) == 0);
            step(r, c, nn);
            n_cmp++;
            if (digit0 !== m_d0 || digit1 !== m_d1 || numValid !== 2'(m_nv)
                || newDigit !== m_nd || keyErr !== m_ke) begin
                n_bad++;
                $display("FAIL random_cycle_%0d got d0=%h d1=%h nv=%0d nd=%b ke=%b want d0=%h d1=%h nv=%0d nd=%b ke=%b",
                         i, digit0, digit1, numValid, newDigit, keyErr, m_d0, m_d1, m_nv, m_nd, m_ke);
            end
            n_cmp++;
            if ((newDigit && keyErr) !== 1'b0) begin
                n_bad++;
                $display("FAIL random_pulse_overlap_%0d got nd=%b ke=%b want not both", i, newDigit, keyErr);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        model_reset();
        reset = 1'b1; rows = 4'd0; cols = 4'd0; newNum = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_key();
        test_history();
        test_holdoff();
        test_diff_key();
        test_invalid();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
